// File: rtl/ewrapper_tx_pkg.sv
// Shared constants, FSM state type and a width helper for the TX slot scheduler.
package ewrapper_tx_pkg;

  localparam int SLOT_CYCLES = 4;
  localparam bit IDLE_WORD   = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Minimum number of bits to hold values 0..n-1 (at least 1).
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ewrapper_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module ewrapper_rr_arb #(
  parameter int NREQ = 3,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    // Walk from the farthest offset down so the nearest requester is assigned last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % NREQ);
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = j;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ewrapper_tx_slot_sched.sv
// Packet-granular round-robin scheduler presenting one word per 4-cycle serializer slot.
module ewrapper_tx_slot_sched
  import ewrapper_tx_pkg::*;
#(
  parameter  int NREQ      = 3,
  parameter  int DW        = 72,
  parameter  int MAX_BEATS = 16,
  localparam int IW        = clog2(NREQ),
  localparam int BW        = clog2(MAX_BEATS + 1)
) (
  input  logic               txo_lclk,
  input  logic               reset,
  input  logic               slot_sync,
  input  logic               tx_wait_in,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_last,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [DW-1:0]      data_out,
  output logic               frame_out,
  output logic [IW-1:0]      grant_id,
  output logic               busy,
  output logic               err_underrun,
  output logic               err_overlen
);

  logic [1:0]      slot_cnt;
  logic            tick;
  logic            wait_m, wait_s;
  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic [BW-1:0]   beat_cnt, beat_nxt;
  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic [IW-1:0]   sel;
  logic            xfer, underrun, ovl;

  ewrapper_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // A realign pulse always starts a new slot, even mid-slot.
  assign tick = ~reset & (slot_sync | (slot_cnt == 2'(SLOT_CYCLES - 1)));
  assign busy = (state == SEND);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    beat_nxt  = beat_cnt;
    req_ready = '0;
    sel       = grant_id;
    xfer      = 1'b0;
    underrun  = 1'b0;
    ovl       = 1'b0;
    if (tick) begin
      if (state == IDLE) begin
        if (arb_any && !wait_s) begin
          sel       = arb_idx;
          xfer      = 1'b1;
          req_ready = arb_grant;
          beat_nxt  = BW'(1);
        end
      end else if (req_valid[grant_id]) begin
        xfer                = 1'b1;
        req_ready[grant_id] = 1'b1;
        beat_nxt            = beat_cnt + BW'(1);
      end else begin
        underrun = 1'b1;
      end
      if (xfer) begin
        if (req_last[sel] || beat_nxt == BW'(MAX_BEATS)) begin
          state_nxt = IDLE;
          ptr_nxt   = (sel == IW'(NREQ - 1)) ? '0 : sel + IW'(1);
          ovl       = ~req_last[sel];
        end else begin
          state_nxt = SEND;
        end
      end
    end
  end

  always_ff @(posedge txo_lclk or posedge reset) begin
    if (reset) begin
      slot_cnt     <= '0;
      wait_m       <= 1'b0;
      wait_s       <= 1'b0;
      state        <= IDLE;
      ptr          <= '0;
      beat_cnt     <= '0;
      data_out     <= '0;
      frame_out    <= 1'b0;
      grant_id     <= '0;
      err_underrun <= 1'b0;
      err_overlen  <= 1'b0;
    end else begin
      slot_cnt     <= tick ? 2'd0 : slot_cnt + 2'd1;
      wait_m       <= tx_wait_in;
      wait_s       <= wait_m;
      state        <= state_nxt;
      ptr          <= ptr_nxt;
      beat_cnt     <= beat_nxt;
      err_underrun <= underrun;
      err_overlen  <= ovl;
      // Word and frame are held for the whole slot.
      if (tick) begin
        data_out  <= xfer ? req_data[int'(sel)*DW +: DW] : {DW{IDLE_WORD}};
        frame_out <= xfer;
        if (xfer) grant_id <= sel;
      end
    end
  end

endmodule

// File: tb/tb_ewrapper_tx_slot_sched.sv
// Randomized bench for the TX slot scheduler against a slot-level packet model.
module tb_ewrapper_tx_slot_sched;

  localparam int NREQ      = 3;
  localparam int DW        = 72;
  localparam int MAX_BEATS = 16;
  localparam int IW        = 2;

  logic               txo_lclk = 1'b0;
  logic               reset;
  logic               slot_sync;
  logic               tx_wait_in;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_last;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [DW-1:0]      data_out;
  logic               frame_out;
  logic [IW-1:0]      grant_id;
  logic               busy;
  logic               err_underrun;
  logic               err_overlen;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: slot phase, wait history, packet owner and progress.
  int          m_phase, m_wait_d1, m_wait_d2, m_ptr, m_gid, m_beats;
  bit          m_in_pkt, m_frame, m_eu, m_eo;
  logic [DW-1:0] m_data;

  ewrapper_tx_slot_sched #(.NREQ(NREQ), .DW(DW), .MAX_BEATS(MAX_BEATS)) dut (
    .txo_lclk     (txo_lclk),
    .reset        (reset),
    .slot_sync    (slot_sync),
    .tx_wait_in   (tx_wait_in),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .data_out     (data_out),
    .frame_out    (frame_out),
    .grant_id     (grant_id),
    .busy         (busy),
    .err_underrun (err_underrun),
    .err_overlen  (err_overlen)
  );

  initial forever #5 txo_lclk = ~txo_lclk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [95:0] w;
    w = {$urandom(), $urandom(), $urandom()};
    return w[DW-1:0];
  endfunction

  task automatic model_reset();
    m_phase = 0; m_wait_d1 = 0; m_wait_d2 = 0; m_ptr = 0; m_gid = 0; m_beats = 0;
    m_in_pkt = 0; m_frame = 0; m_eu = 0; m_eo = 0; m_data = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},  data_out, 0);
    check({tag, "_frame"}, frame_out, 0);
    check({tag, "_gid"},   grant_id, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_eu"},    err_underrun, 0);
    check({tag, "_eo"},    err_overlen, 0);
    check({tag, "_ready"}, req_ready, 0);
  endtask

  // One clock: check the handshake, predict the slot result, then compare registered outputs.
  task automatic step();
    bit              tick;
    int              sel;
    logic [NREQ-1:0] exp_rdy;
    #1;
    tick    = slot_sync || (m_phase == 3);
    sel     = -1;
    exp_rdy = '0;
    if (tick) begin
      if (!m_in_pkt) begin
        if (m_wait_d2 == 0)
          for (int k = 0; k < NREQ; k++)
            if (sel < 0 && req_valid[(m_ptr + k) % NREQ]) sel = (m_ptr + k) % NREQ;
      end else if (req_valid[m_gid]) begin
        sel = m_gid;
      end
    end
    if (sel >= 0) exp_rdy[sel] = 1'b1;
    check("req_ready", req_ready, exp_rdy);

    m_eu = 0;
    m_eo = 0;
    if (tick) begin
      if (sel >= 0) begin
        m_data  = req_data[sel*DW +: DW];
        m_frame = 1;
        m_beats = m_in_pkt ? m_beats + 1 : 1;
        m_gid   = sel;
        if (req_last[sel] || m_beats == MAX_BEATS) begin
          m_eo     = !req_last[sel];
          m_in_pkt = 0;
          m_ptr    = (sel + 1) % NREQ;
        end else begin
          m_in_pkt = 1;
        end
      end else begin
        m_data  = '0;
        m_frame = 0;
        m_eu    = m_in_pkt;
      end
    end
    m_phase   = tick ? 0 : m_phase + 1;
    m_wait_d2 = m_wait_d1;
    m_wait_d1 = tx_wait_in;

    @(posedge txo_lclk);
    #1;
    check("data_out",     data_out, m_data);
    check("frame_out",    frame_out, m_frame);
    check("grant_id",     grant_id, m_gid);
    check("busy",         busy, m_in_pkt);
    check("err_underrun", err_underrun, m_eu);
    check("err_overlen",  err_overlen, m_eo);
  endtask

  task automatic drive_rand(input logic [NREQ-1:0] mask, input int pv, input int pl,
                            input int pw, input int ps);
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = mask[i] && ($urandom_range(99) < pv);
      req_last[i]  = ($urandom_range(99) < pl);
      req_data[i*DW +: DW] = rand_word();
    end
    tx_wait_in = ($urandom_range(99) < pw);
    slot_sync  = ($urandom_range(99) < ps);
  endtask

  task automatic drive_single_req0();
    req_valid  = 3'b001;
    req_last   = 3'b001;
    req_data   = '0;
    req_data[DW-1:0] = rand_word();
    tx_wait_in = 1'b0;
    slot_sync  = 1'b0;
  endtask

  task automatic first_tick_check(input string tag);
    for (int i = 1; i <= 4; i++) begin
      step();
      check(tag, frame_out, (i == 4));
    end
  endtask

  int ph_mask [5] = '{1, 7, 7, 7, 3};
  int ph_pv   [5] = '{100, 100, 80, 70, 100};
  int ph_pl   [5] = '{30, 100, 25, 30, 0};
  int ph_pw   [5] = '{0, 0, 30, 10, 0};
  int ph_ps   [5] = '{0, 0, 0, 5, 0};
  int ph_len  [5] = '{300, 200, 600, 600, 300};

  initial begin
    reset = 1'b1; slot_sync = 1'b0; tx_wait_in = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0;
    model_reset();
    repeat (3) @(posedge txo_lclk);
    #1;
    check_all_zero("rst");

    drive_single_req0();
    reset = 1'b0;
    first_tick_check("first_tick");

    // Realign one cycle into a slot, then let ticks resume every four cycles.
    step();
    slot_sync = 1'b1;
    step();
    check("sync_frame", frame_out, 1);
    slot_sync = 1'b0;
    repeat (8) step();

    for (int p = 0; p < 5; p++)
      for (int c = 0; c < ph_len[p]; c++) begin
        drive_rand(NREQ'(ph_mask[p]), ph_pv[p], ph_pl[p], ph_pw[p], ph_ps[p]);
        step();
      end

    // Abort a packet in flight with an asynchronous reset.
    for (int c = 0; c < 60 && !m_in_pkt; c++) begin
      drive_rand(3'b011, 100, 0, 0, 0);
      step();
    end
    check("mid_send_busy", busy, 1);
    reset = 1'b1;
    #1;
    check_all_zero("rst_mid");
    model_reset();
    repeat (2) @(posedge txo_lclk);
    #1;
    drive_single_req0();
    reset = 1'b0;
    first_tick_check("first_tick_after_abort");

    for (int c = 0; c < 400; c++) begin
      drive_rand(3'b111, 75, 35, 15, 4);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
